sm3_pad_core: RTL and testbench

SM3 message padding stage. Accepts a byte-aligned message as a stream of big-endian words, forwards the words and appends the SM3 padding: one 1-bit, zero fill, and the 64-bit big-endian message bit length. It emits whole 512-bit blocks as 16 (32-bit) or 8 (64-bit) words. It sits between the message source and the compression/expansion core, and its output stream (pad_otpt_*) is what sm3_if carries to the pad monitor.

---
 rtl/sm3_pad_pkg.sv | 53 +++++
 rtl/sm3_pad_lst_wrd.sv | 35 +++
 rtl/sm3_pad_core.sv | 136 +++++++++++++
 tb/tb_sm3_pad_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pad_pkg.sv
// Shared types, constants and helpers for the SM3 message padding stage.
package sm3_pad_pkg;

    localparam int         SM3_INPT_DW_32 = 32;
    localparam int         SM3_INPT_DW_64 = 64;
    localparam logic [7:0] PAD_BYTE       = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        LEN  = 2'd3
    } pad_state_e;

    // Words per 512-bit block for a given word width.
    function automatic int wpb_f(input int dw);
        return 512 / dw;
    endfunction

    // Position of the first length word inside the final block.
    function automatic int len_pos_f(input int dw);
        return (dw == SM3_INPT_DW_64) ? 7 : 14;
    endfunction

    // Number of valid bytes in a (MSB-aligned, up to 8-bit) byte mask.
    function automatic logic [3:0] mask_to_bytes(input logic [7:0] mask);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, mask[i]};
        end
        return n;
    endfunction

    // Keep valid bytes, put 0x80 in the first invalid byte, zero the rest.
    // Data and mask are MSB-aligned in a 64-bit / 8-bit container; byte 0 is the MSB byte.
    function automatic logic [63:0] pad_last_word(input logic [63:0] d, input logic [7:0] mask);
        logic [63:0] r;
        logic        prev_vld;
        r        = '0;
        prev_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (mask[7-i]) begin
                r[63-8*i -: 8] = d[63-8*i -: 8];
            end else if (prev_vld) begin
                r[63-8*i -: 8] = PAD_BYTE;
            end
            prev_vld = mask[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sm3_pad_lst_wrd.sv
// Combinational merge of the final message word: inserts the 0x80 pad byte after
// the last valid byte, zeroes the trailing bytes and reports the valid-byte count.
module sm3_pad_lst_wrd
    import sm3_pad_pkg::*;
#(
    parameter int INPT_DW = SM3_INPT_DW_32
) (
    input  logic [INPT_DW-1:0]   d_i,
    input  logic [INPT_DW/8-1:0] mask_i,
    output logic [INPT_DW-1:0]   d_o,
    output logic [3:0]           nbytes_o
);

    logic [63:0] d_al;
    logic [7:0]  m_al;
    logic [63:0] merged;

    // Align the word into the 64-bit helper container, merge, and slice back.
    always_comb begin
        d_al                   = '0;
        m_al                   = '0;
        d_al[63 -: INPT_DW]    = d_i;
        m_al[7 -: INPT_DW/8]   = mask_i;
        merged                 = pad_last_word(d_al, m_al);
        d_o                    = merged[63 -: INPT_DW];
        nbytes_o               = mask_to_bytes(m_al);
    end

    // For narrow words the low half of the container carries no information.
    if (INPT_DW < 64) begin : g_narrow
        logic unused_lo;
        assign unused_lo = ^merged[63-INPT_DW:0];
    end

endmodule

// File: rtl/sm3_pad_core.sv
// SM3 message padding stage: forwards message words with one cycle of latency
// and appends the 0x80 marker, zero fill and the 64-bit big-endian bit length,
// closing out whole 512-bit blocks.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for the first word of a message, rdy high
// DATA  | forwarding message words, rdy high
// PAD   | emitting the pending 0x80 word (full last word) and zero fill
// LEN   | emitting the length word(s); last one carries pad_otpt_lst
module sm3_pad_core
    import sm3_pad_pkg::*;
#(
    parameter int INPT_DW = SM3_INPT_DW_32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INPT_DW-1:0]   msg_inpt_d,
    input  logic                 msg_inpt_vld,
    input  logic                 msg_inpt_lst,
    input  logic [INPT_DW/8-1:0] msg_inpt_vld_byte,
    output logic                 msg_inpt_rdy,
    output logic [INPT_DW-1:0]   pad_otpt_d,
    output logic                 pad_otpt_vld,
    output logic                 pad_otpt_lst
);

    localparam int WPB = wpb_f(INPT_DW);
    localparam int CW  = $clog2(WPB);

    localparam logic [CW-1:0]      LEN_POS  = CW'(len_pos_f(INPT_DW));
    localparam logic [CW-1:0]      LAST_POS = CW'(WPB - 1);
    localparam logic [INPT_DW-1:0] PAD_WORD = {PAD_BYTE, {(INPT_DW-8){1'b0}}};

    pad_state_e         state_q;
    logic [CW-1:0]      wcnt_q;
    logic [63:0]        bitlen_q;
    logic               one_pend_q;
    logic               rdy_q;
    logic [INPT_DW-1:0] otpt_d_q;
    logic               otpt_vld_q;
    logic               otpt_lst_q;

    logic [INPT_DW-1:0] lst_d;
    logic [3:0]         lst_nbytes;
    logic               lst_full;
    logic               accept;
    logic [CW-1:0]      wcnt_d;
    logic [63:0]        lst_bits;

    sm3_pad_lst_wrd #(
        .INPT_DW (INPT_DW)
    ) u_lst_wrd (
        .d_i      (msg_inpt_d),
        .mask_i   (msg_inpt_vld_byte),
        .d_o      (lst_d),
        .nbytes_o (lst_nbytes)
    );

    // Handshake qualification and next word position.
    always_comb begin
        accept   = msg_inpt_vld & rdy_q;
        lst_full = &msg_inpt_vld_byte;
        wcnt_d   = wcnt_q + 1'b1;
        lst_bits = {57'd0, lst_nbytes, 3'b000};
    end

    // Padding FSM with registered outputs; every emitted word advances wcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            bitlen_q   <= '0;
            one_pend_q <= 1'b0;
            rdy_q      <= 1'b0;
            otpt_d_q   <= '0;
            otpt_vld_q <= 1'b0;
            otpt_lst_q <= 1'b0;
        end else begin
            otpt_vld_q <= 1'b0;
            otpt_lst_q <= 1'b0;
            otpt_d_q   <= '0;
            case (state_q)
                IDLE, DATA: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        otpt_vld_q <= 1'b1;
                        wcnt_q     <= wcnt_d;
                        if (!msg_inpt_lst) begin
                            otpt_d_q <= msg_inpt_d;
                            bitlen_q <= bitlen_q + 64'(INPT_DW);
                            state_q  <= DATA;
                        end else begin
                            // A full last word passes unchanged; its marker follows in PAD.
                            otpt_d_q   <= lst_d;
                            bitlen_q   <= bitlen_q + lst_bits;
                            one_pend_q <= lst_full;
                            rdy_q      <= 1'b0;
                            state_q    <= (!lst_full && (wcnt_d == LEN_POS)) ? LEN : PAD;
                        end
                    end
                end
                PAD: begin
                    otpt_vld_q <= 1'b1;
                    otpt_d_q   <= one_pend_q ? PAD_WORD : '0;
                    one_pend_q <= 1'b0;
                    wcnt_q     <= wcnt_d;
                    state_q    <= (wcnt_d == LEN_POS) ? LEN : PAD;
                end
                LEN: begin
                    otpt_vld_q <= 1'b1;
                    if (wcnt_q == LAST_POS) begin
                        otpt_d_q   <= bitlen_q[INPT_DW-1:0];
                        otpt_lst_q <= 1'b1;
                        bitlen_q   <= '0;
                        wcnt_q     <= '0;
                        rdy_q      <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        otpt_d_q <= bitlen_q[63 -: INPT_DW];
                        wcnt_q   <= wcnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign msg_inpt_rdy = rdy_q;
    assign pad_otpt_d   = otpt_d_q;
    assign pad_otpt_vld = otpt_vld_q;
    assign pad_otpt_lst = otpt_lst_q;

endmodule

// File: tb/tb_sm3_pad_core.sv
// Scoreboard bench for sm3_pad_core: expected padded streams are derived from the
// message bytes (append 0x80, zero to 56 mod 64, append bit length) and checked
// by an independent output monitor.
module tb_sm3_pad_core;

    localparam int DW  = 32;
    localparam int BPW = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  msg_inpt_d = '0;
    logic           msg_inpt_vld = 1'b0;
    logic           msg_inpt_lst = 1'b0;
    logic [BPW-1:0] msg_inpt_vld_byte = '0;
    logic           msg_inpt_rdy;
    logic [DW-1:0]  pad_otpt_d;
    logic           pad_otpt_vld;
    logic           pad_otpt_lst;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_d_q[$];
    bit            exp_l_q[$];
    byte unsigned  msg_q[$];

    always #5 clk = ~clk;

    sm3_pad_core #(.INPT_DW(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .msg_inpt_d        (msg_inpt_d),
        .msg_inpt_vld      (msg_inpt_vld),
        .msg_inpt_lst      (msg_inpt_lst),
        .msg_inpt_vld_byte (msg_inpt_vld_byte),
        .msg_inpt_rdy      (msg_inpt_rdy),
        .pad_otpt_d        (pad_otpt_d),
        .pad_otpt_vld      (pad_otpt_vld),
        .pad_otpt_lst      (pad_otpt_lst)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte-level SM3 padding of msg_q, packed into big-endian words.
    task automatic push_expected(output int n_words);
        byte unsigned    p[$];
        longint unsigned bl;
        logic [DW-1:0]   wd;
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
        n_words = p.size() / BPW;
        for (int w = 0; w < n_words; w++) begin
            wd = '0;
            for (int b = 0; b < BPW; b++) wd = (wd << 8) | DW'(p[w*BPW+b]);
            exp_d_q.push_back(wd);
            exp_l_q.push_back(w == n_words - 1);
        end
    endtask

    // Present one word and hold it until accepted (called at posedge+1).
    task automatic drive(input logic [DW-1:0] d, input bit l, input logic [BPW-1:0] m,
                         output bit lst_seen);
        int guard;
        bit r;
        guard             = 0;
        r                 = 1'b0;
        lst_seen          = 1'b0;
        msg_inpt_d        = d;
        msg_inpt_lst      = l;
        msg_inpt_vld_byte = m;
        msg_inpt_vld      = 1'b1;
        do begin
            @(negedge clk);
            r        = msg_inpt_rdy;
            lst_seen = pad_otpt_lst;
            @(posedge clk);
            #1;
            guard++;
        end while (!r && guard < 500);
        chk("handshake_accepted", 64'(r), 64'd1);
        msg_inpt_vld = 1'b0;
        msg_inpt_lst = 1'b0;
    endtask

    // Send msg_q as a message; optionally check the padding tail timing.
    task automatic send_msg(input bit empty_tail, input bit bubbles, input bit wait_end,
                            output bit lst_first);
        int             len, nfull, rem, n_in, n_exp, nb, cnt, rlow;
        bit             ls, seen;
        logic [DW-1:0]  d;
        logic [BPW-1:0] m;
        len   = msg_q.size();
        nfull = len / BPW;
        rem   = len % BPW;
        lst_first = 1'b0;
        push_expected(n_exp);
        n_in = (rem != 0 || empty_tail || nfull == 0) ? nfull + 1 : nfull;
        for (int k = 0; k < n_in; k++) begin
            nb = len - k * BPW;
            if (nb > BPW) nb = BPW;
            ls = (k == n_in - 1);
            d  = '0;
            for (int b = 0; b < BPW; b++)
                d = (d << 8) | DW'((b < nb) ? msg_q[k*BPW+b] : 8'($urandom));
            m = '0;
            if (ls) begin
                for (int b = 0; b < nb; b++) m[BPW-1-b] = 1'b1;
            end else begin
                m = BPW'($urandom);
            end
            if (bubbles && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            drive(d, ls, m, seen);
            if (k == 0) lst_first = seen;
        end
        if (wait_end) begin
            cnt  = 0;
            rlow = 0;
            seen = 1'b0;
            while (!seen && cnt < 200) begin
                @(negedge clk);
                cnt++;
                if (!msg_inpt_rdy) rlow++;
                seen = pad_otpt_lst;
            end
            chk("lst_reached", 64'(seen), 64'd1);
            chk("pad_tail_cycles", 64'(cnt), 64'(n_exp - n_in + 1));
            chk("rdy_low_cycles", 64'(rlow), 64'(n_exp - n_in));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    // Output monitor: every valid output word is checked against the scoreboard.
    initial begin
        logic [DW-1:0] ed;
        bit            el;
        forever begin
            @(negedge clk);
            if (pad_otpt_vld) begin
                if (exp_d_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h with nothing expected (t=%0t)",
                             pad_otpt_d, $time);
                end else begin
                    ed = exp_d_q.pop_front();
                    el = exp_l_q.pop_front();
                    chk("out_word", 64'(pad_otpt_d), 64'(ed));
                    chk("out_lst", 64'(pad_otpt_lst), 64'(el));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lf1, lf2;
        int vcnt;
        #12;
        chk("rst_vld", 64'(pad_otpt_vld), 64'd0);
        chk("rst_lst", 64'(pad_otpt_lst), 64'd0);
        chk("rst_d", 64'(pad_otpt_d), 64'd0);
        chk("rst_rdy", 64'(msg_inpt_rdy), 64'd0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after_release", 64'(msg_inpt_rdy), 64'd1);
        @(posedge clk);
        #1;

        // "abc"
        set_abc();
        send_msg(1'b0, 1'b0, 1'b1, lf1);

        // 64 bytes, full masks: second block is marker + length
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(8'h61 + (i % 4)));
        send_msg(1'b0, 1'b0, 1'b1, lf1);

        // empty message
        msg_q.delete();
        send_msg(1'b0, 1'b0, 1'b1, lf1);

        // 56 bytes: marker at position 14 forces a second block
        msg_q.delete();
        for (int i = 0; i < 56; i++) msg_q.push_back(8'(8'h61 + (i % 4)));
        send_msg(1'b0, 1'b0, 1'b1, lf1);

        // back-to-back "abc" with vld held high
        set_abc();
        send_msg(1'b0, 1'b0, 1'b0, lf1);
        set_abc();
        send_msg(1'b0, 1'b0, 1'b1, lf2);
        chk("b2b_accept_on_lst", 64'(lf2), 64'd1);

        // reset in the middle of a 16-word message
        msg_q.delete();
        for (int k = 0; k < 5; k++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            exp_d_q.push_back(w);
            exp_l_q.push_back(1'b0);
            drive(w, 1'b0, '1, lf1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_vld", 64'(pad_otpt_vld), 64'd0);
        chk("midrst_d", 64'(pad_otpt_d), 64'd0);
        chk("midrst_rdy", 64'(msg_inpt_rdy), 64'd0);
        exp_d_q.delete();
        exp_l_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (pad_otpt_vld) vcnt++;
        end
        chk("no_partial_after_reset", 64'(vcnt), 64'd0);
        @(posedge clk);
        #1;
        set_abc();
        send_msg(1'b0, 1'b0, 1'b1, lf1);

        // randomized messages
        for (int t = 0; t < 40; t++) begin
            int len;
            len = $urandom_range(0, 150);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            send_msg(1'($urandom), 1'($urandom), 1'b1, lf1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_d_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
